// File: rtl/uc_tx.sv
// Serial transmitter for one (max730, max850) result pair to the microcontroller.
// Frame: start 0, max730 MSB-first, max850 MSB-first, stop 1; each bit held CLKS_PER_BIT clocks.
module uc_tx #(
  parameter int DATLEN       = 12,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [0:DATLEN-1] max730,
  input  logic [0:DATLEN-1] max850,
  input  logic              valid,
  output logic              ready,
  output logic              out,
  output logic              busy,
  output logic              done,
  output logic [1:0]        fsm_state
);

  // Handshake: a pair is accepted on a rising edge where valid && ready;
  // ready stays low until the frame (including its stop bit) has fully left.
  localparam int NBITS = 2 * DATLEN;
  localparam int BW    = $clog2(NBITS);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam logic [7:0]    CYC_LAST = 8'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(NBITS - 1);

  logic [1:0]       state;
  logic [7:0]       cyc;
  logic [BW-1:0]    bitcnt;
  logic [NBITS-1:0] sreg;
  logic             bit_end;

  assign bit_end   = (cyc == CYC_LAST);
  assign busy      = ~ready;
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cyc    <= '0;
      bitcnt <= '0;
      sreg   <= '0;
      out    <= 1'b1;
      ready  <= 1'b1;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          out   <= 1'b1;
          ready <= 1'b1;
          cyc   <= '0;
          if (valid && ready) begin
            // max730[0] lands in the MSB of the shift register and goes out first.
            sreg  <= {max730, max850};
            out   <= 1'b0;
            ready <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (bit_end) begin
            cyc    <= '0;
            bitcnt <= '0;
            out    <= sreg[NBITS-1];
            sreg   <= {sreg[NBITS-2:0], 1'b0};
            state  <= DATA;
          end else begin
            cyc <= cyc + 8'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cyc <= '0;
            // bitcnt names the data bit currently on the line.
            if (bitcnt == BIT_LAST) begin
              out   <= 1'b1;
              state <= STOP;
            end else begin
              bitcnt <= bitcnt + BW'(1);
              out    <= sreg[NBITS-1];
              sreg   <= {sreg[NBITS-2:0], 1'b0};
            end
          end else begin
            cyc <= cyc + 8'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            cyc   <= '0;
            ready <= 1'b1;
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            cyc <= cyc + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uc_tx.sv
// Directed bench for uc_tx: default timing instance (CPB=4) plus a CPB=1 instance.
// Expected serial frames are built from the words by an MSB-first queue model.
module tb_uc_tx;
  localparam int DL = 12;

  logic          clk = 1'b0;
  logic          reset, valid, ready, out, busy, done;
  logic [0:DL-1] max730, max850;
  logic [1:0]    st0;

  logic          reset1, valid1, ready1, out1, busy1, done1;
  logic [0:DL-1] a1, b1;
  logic [1:0]    st1;

  logic [0:0]    exp_q[$];
  int            checks   = 0;
  int            failures = 0;

  uc_tx #(.DATLEN(DL), .CLKS_PER_BIT(4)) dut (
    .clk(clk), .reset(reset), .max730(max730), .max850(max850), .valid(valid),
    .ready(ready), .out(out), .busy(busy), .done(done), .fsm_state(st0)
  );

  uc_tx #(.DATLEN(DL), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .reset(reset1), .max730(a1), .max850(b1), .valid(valid1),
    .ready(ready1), .out(out1), .busy(busy1), .done(done1), .fsm_state(st1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic build_exp(input logic [DL-1:0] a, input logic [DL-1:0] b);
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = DL - 1; i >= 0; i--) exp_q.push_back(a[i]);
    for (int i = DL - 1; i >= 0; i--) exp_q.push_back(b[i]);
    exp_q.push_back(1'b1);
  endtask

  // Called just after the accepting edge; checks every cycle of the frame on dut.
  // ncyc < 104 stops early (mid-frame); scramble wiggles the inputs while busy.
  task automatic check_frame(input logic [DL-1:0] a, input logic [DL-1:0] b,
                             input bit scramble, input int ncyc);
    logic [0:0] e;
    int n;
    build_exp(a, b);
    n = 0;
    for (int k = 0; k < 2 * DL + 2; k++) begin
      e = exp_q.pop_front();
      for (int c = 0; c < 4; c++) begin
        if (n < ncyc) begin
          chk("frame_out", out, e);
          chk("frame_ready_low", ready, 1'b0);
          chk("frame_done_low", done, 1'b0);
          if (scramble) begin
            max730 = DL'($urandom);
            max850 = DL'($urandom);
            valid  = (n == ncyc - 1) ? 1'b0 : 1'($urandom_range(0, 1));
          end
          tick();
          n++;
        end
      end
    end
    if (ncyc >= (2 * DL + 2) * 4) begin
      chk("end_ready", ready, 1'b1);
      chk("end_done", done, 1'b1);
      chk("end_busy", busy, 1'b0);
      chk("end_out", out, 1'b1);
    end
  endtask

  initial begin
    reset = 1'b1; valid = 1'b0; max730 = '0; max850 = '0;
    reset1 = 1'b1; valid1 = 1'b0; a1 = '0; b1 = '0;
    tick(); tick();
    chk("rst_out", out, 1'b1);
    chk("rst_ready", ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_state", st0, 2'd0);
    chk("rst1_out", out1, 1'b1);
    reset = 1'b0; reset1 = 1'b0;
    tick();
    chk("idle_out", out, 1'b1);

    // Single frame
    max730 = 12'hA5C; max850 = 12'h3F1; valid = 1'b1;
    tick();
    valid = 1'b0;
    check_frame(12'hA5C, 12'h3F1, 1'b0, 104);
    tick();
    chk("t1_done_pulse", done, 1'b0);
    chk("t1_idle_ready", ready, 1'b1);

    // Back-to-back with valid held high
    max730 = 12'hFFF; max850 = 12'h000; valid = 1'b1;
    tick();
    max730 = 12'h001; max850 = 12'h800;
    check_frame(12'hFFF, 12'h000, 1'b0, 104);
    tick();
    valid = 1'b0;
    check_frame(12'h001, 12'h800, 1'b0, 104);
    tick();
    chk("t2_idle_out", out, 1'b1);

    // Input stability while busy
    max730 = 12'h6B2; max850 = 12'h94D; valid = 1'b1;
    tick();
    check_frame(12'h6B2, 12'h94D, 1'b1, 104);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t3_no_extra_out", out, 1'b1);
      chk("t3_no_extra_ready", ready, 1'b1);
    end

    // Reset at bit 10
    max730 = 12'h123; max850 = 12'hFED; valid = 1'b1;
    tick();
    valid = 1'b0;
    check_frame(12'h123, 12'hFED, 1'b0, 40);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t4_out", out, 1'b1);
    chk("t4_ready", ready, 1'b1);
    chk("t4_busy", busy, 1'b0);
    chk("t4_done", done, 1'b0);
    for (int i = 0; i < 110; i++) begin
      tick();
      chk("t4_quiet_done", done, 1'b0);
      chk("t4_quiet_out", out, 1'b1);
    end
    max730 = 12'h8C3; max850 = 12'h17E; valid = 1'b1;
    tick();
    valid = 1'b0;
    check_frame(12'h8C3, 12'h17E, 1'b0, 104);
    tick();

    // CLKS_PER_BIT = 1
    a1 = 12'h555; b1 = 12'hAAA; valid1 = 1'b1;
    tick();
    valid1 = 1'b0;
    build_exp(12'h555, 12'hAAA);
    for (int k = 0; k < 2 * DL + 2; k++) begin
      chk("t5_out", out1, exp_q.pop_front());
      chk("t5_ready_low", ready1, 1'b0);
      tick();
    end
    chk("t5_ready", ready1, 1'b1);
    chk("t5_done", done1, 1'b1);
    chk("t5_busy", busy1, 1'b0);

    // Reset and valid together
    reset = 1'b1; valid = 1'b1; max730 = 12'hABC; max850 = 12'h123;
    tick();
    chk("t6_ready", ready, 1'b1);
    chk("t6_out", out, 1'b1);
    chk("t6_busy", busy, 1'b0);
    reset = 1'b0; valid = 1'b0;
    tick();
    chk("t6_after_out", out, 1'b1);
    chk("t6_after_ready", ready, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uc_tx.md
# uc_tx

Serial transmitter that carries one result pair from the DSP path to the microcontroller. It accepts the 730 nm and 850 nm maxima (`max730`, `max850`) as parallel words through a valid/ready handshake. It then shifts them out on a single wire as one framed bit stream. It is the outbound counterpart of the ADC bit collector, sits after the FFT/filter/maximum stage in `process`, and drives the board line to the microcontroller.

## Interface
Parameters:
- `DATLEN`, default 12 (`ADC_DATLEN`): width of each word.
- `CLKS_PER_BIT`, default 4: clock cycles each serial bit is held; legal range 1..255.

Ports:
- `clk`, in, 1: the single clock. All logic is rising-edge.
- `reset`, in, 1: synchronous, active-high.
- `max730`, in, [0:DATLEN-1]: first word. Index 0 is the MSB.
- `max850`, in, [0:DATLEN-1]: second word. Index 0 is the MSB.
- `valid`, in, 1: the input pair is presented.
- `ready`, out, 1: the block can accept a pair.
- `out`, out, 1: serial line. Idles high.
- `busy`, out, 1: a frame is in progress. Always equals `!ready`.
- `done`, out, 1: one-cycle pulse at the end of each frame.

## Operation
- Frame layout, in order, 2·DATLEN+2 bits (26 at default):
  - start bit 0;
  - `max730[0]`..`max730[DATLEN-1]`;
  - `max850[0]`..`max850[DATLEN-1]`;
  - stop bit 1.
- Accept: on a rising edge with `valid && ready`:
  - both words load into a 2·DATLEN shift register;
  - `out<=0`, `ready<=0`, `busy<=1`;
  - the state goes to START.
- Inputs are sampled only at acceptance. Changes on `max730`/`max850`/`valid` while busy are ignored.
- State machine, one state per phase:
  - IDLE: `out=1`, `ready=1`.
  - START: hold for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: shift the register once per bit period. Bit counter runs 0..2·DATLEN-1, then go to STOP.
  - STOP: `out=1` for CLKS_PER_BIT cycles, then go to IDLE.
- Counters:
  - cycle counter: 8 bits, counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary;
  - bit counter: ceil(log2(2·DATLEN)) bits.
- End of frame: on the STOP-to-IDLE edge, `ready<=1`, `busy<=0`, `done<=1` for exactly one cycle. `done` is otherwise 0.
- `out` is a registered output with no combinational path from the inputs.
- Reset:
  - values: `out=1`, `ready=1`, `busy=0`, `done=0`, state IDLE, counters 0, shift register 0;
  - `valid` is ignored in any cycle where `reset=1`;
  - a reset asserted mid-frame aborts the frame. `out` is 1 from the next edge and no `done` is issued.
- Reset and `valid` asserted in the same cycle: reset wins and nothing is accepted.

## Timing
- Acceptance at edge E0. The start bit is visible on `out` for cycles E0..E0+CPB-1 (CPB = CLKS_PER_BIT).
- Bit k of the frame (k=0 is the start bit) occupies cycles E0+k·CPB .. E0+(k+1)·CPB-1.
- `ready` is low for exactly (2·DATLEN+2)·CPB cycles. `ready` and `done` rise at edge E0+(2·DATLEN+2)·CPB.
- Back-to-back: if `valid` is held high continuously, the next acceptance happens at the edge after `ready` rises. This leaves exactly one idle cycle at `out=1` between the stop bit and the next start bit.
- Frame period under continuous `valid`: (2·DATLEN+2)·CPB+1 cycles, which is 105 at default.

## Test plan
1. Single frame at default parameters.
   - Stimulus: `max730`=12'hA5C, `max850`=12'h3F1, one-cycle `valid`.
   - Required: sampling `out` every 4 cycles gives 0, 1010 0101 1100, 0011 1111 0001, 1.
   - Required: `ready` low for 104 cycles; `done` high for exactly 1 cycle at the end.
2. Back-to-back frames.
   - Stimulus: `valid` held high with pair A (12'hFFF, 12'h000), then pair B (12'h001, 12'h800).
   - Required: two correct frames separated by exactly 1 idle-high cycle; second acceptance 105 cycles after the first.
3. Input stability.
   - Stimulus: during a frame, change `max730`/`max850` every cycle and pulse `valid`.
   - Required: the transmitted bits equal the values captured at acceptance; no extra frame follows.
4. Reset mid-frame.
   - Stimulus: assert `reset` for 1 cycle at bit 10 of a frame.
   - Required: `out=1`, `ready=1`, `busy=0` from the next edge; no `done` pulse; a following `valid` produces a clean full frame.
5. CLKS_PER_BIT=1.
   - Stimulus: pair 12'h555, 12'hAAA.
   - Required: 26-cycle frame alternating 0,0101…,1010…,1; `ready` low for 26 cycles.
6. Reset and `valid` asserted in the same cycle.
   - Required: no acceptance; `out` stays 1 and `ready` stays 1.
